// File: rtl/vx_commit_pkg.sv
// Shared commit-stage types: commit entry layout, arbitration encodings and a thread popcount.
package vx_commit_pkg;
  localparam int CE_NT        = 4;
  localparam int CE_NUM_WARPS = 4;
  localparam int CE_NW_W      = (CE_NUM_WARPS > 1) ? $clog2(CE_NUM_WARPS) : 1;
  localparam int CE_DATAW     = 64;
  localparam int PC_W         = $clog2(CE_NT + 1);

  localparam logic [7:0] ARB_RR   = 8'h52;  // "R"
  localparam logic [7:0] ARB_PRIO = 8'h50;  // "P"

  typedef struct packed {
    logic [CE_NW_W-1:0]  wid;
    logic [CE_NT-1:0]    tmask;
    logic                wb;
    logic                eop;
    logic [CE_DATAW-1:0] data;
  } commit_entry_t;

  function automatic logic [PC_W-1:0] popcount(input logic [CE_NT-1:0] m);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < CE_NT; i++) c = c + PC_W'(m[i]);
    return c;
  endfunction
endpackage

// File: rtl/vx_commit_lane.sv
// One writeback lane: arbitrates NUM_EX execute channels into a BUF_DEPTH commit FIFO and pops the head.
module vx_commit_lane import vx_commit_pkg::*; #(
  parameter int         NUM_EX    = 4,
  parameter int         BUF_DEPTH = 2,
  parameter logic [7:0] ARB_MODE  = ARB_RR
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic          [NUM_EX-1:0] in_valid,
  output logic          [NUM_EX-1:0] in_ready,
  input  commit_entry_t [NUM_EX-1:0] in_entry,
  input  logic                       wb_ready,
  output logic                       wb_valid,
  output logic                       pop,
  output commit_entry_t              head
);
  localparam int EW = (NUM_EX > 1) ? $clog2(NUM_EX) : 1;
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  commit_entry_t [BUF_DEPTH-1:0] mem;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [EW-1:0] rr_ptr, grant;
  logic          found, push, head_vld;
  int            idx;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (int'(p) == BUF_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  generate
    if (ARB_MODE == ARB_RR) begin : g_rr
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  rr_ptr <= '0;
        else if (push) rr_ptr <= (int'(grant) == NUM_EX - 1) ? '0 : grant + EW'(1);
      end
    end else begin : g_prio
      assign rr_ptr = '0;
    end
  endgenerate

  // search starts at the RR pointer; fixed priority pins the pointer at ex0
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int i = 0; i < NUM_EX; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_EX) idx = idx - NUM_EX;
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        grant = EW'(idx);
      end
    end
  end

  // full blocks acceptance even when the head pops this cycle
  assign push = found && (count < CW'(BUF_DEPTH));

  always_comb begin
    in_ready = '0;
    if (push) in_ready[grant] = 1'b1;
  end

  assign head_vld = (count != '0);
  assign head     = mem[rd_ptr];
  assign wb_valid = head_vld && head.wb;
  assign pop      = head_vld && (!head.wb || wb_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_entry[grant];
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/vx_commit_multi.sv
// Commit stage top: LANES commit lanes, registered commit pulses and a two-stage retired-thread counter.
module vx_commit_multi import vx_commit_pkg::*; #(
  parameter int         NUM_EX      = 4,
  parameter int         LANES       = 2,
  parameter int         NUM_THREADS = CE_NT,
  parameter int         NUM_WARPS   = CE_NUM_WARPS,
  parameter int         DATAW       = CE_DATAW,
  parameter int         BUF_DEPTH   = 2,
  parameter logic [7:0] ARB_MODE    = ARB_RR,
  parameter int         CTR_W       = 44,
  localparam int        NW_W        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int        NCH         = NUM_EX * LANES
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NCH-1:0]                    in_valid,
  output logic [NCH-1:0]                    in_ready,
  input  logic [NCH-1:0][NW_W-1:0]          in_wid,
  input  logic [NCH-1:0][NUM_THREADS-1:0]   in_tmask,
  input  logic [NCH-1:0]                    in_wb,
  input  logic [NCH-1:0]                    in_eop,
  input  logic [NCH-1:0][DATAW-1:0]         in_data,
  output logic [LANES-1:0]                  wb_valid,
  input  logic [LANES-1:0]                  wb_ready,
  output logic [LANES-1:0][NW_W-1:0]        wb_wid,
  output logic [LANES-1:0][NUM_THREADS-1:0] wb_tmask,
  output logic [LANES-1:0]                  wb_eop,
  output logic [LANES-1:0][DATAW-1:0]       wb_data,
  output logic [LANES-1:0]                  committed,
  output logic [LANES-1:0][NW_W-1:0]        committed_wid,
  output logic [CTR_W-1:0]                  instret
);
  localparam int SW = $clog2(NUM_THREADS + 1) + $clog2(LANES);

  logic [LANES-1:0]           pop;
  logic [LANES-1:0][PC_W-1:0] pc;
  logic [SW-1:0]              sum, sum_q;
  logic [1:0]                 vld_pipe;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    commit_entry_t [NUM_EX-1:0] ent;
    logic          [NUM_EX-1:0] vld, rdy;
    commit_entry_t              head;
    logic                       cmt_q;
    logic [NW_W-1:0]            cwid_q;

    for (genvar e = 0; e < NUM_EX; e++) begin : g_ch
      localparam int CH = e * LANES + l;
      assign vld[e]       = in_valid[CH];
      assign in_ready[CH] = rdy[e];
      assign ent[e]       = '{wid: in_wid[CH], tmask: in_tmask[CH], wb: in_wb[CH],
                              eop: in_eop[CH], data: in_data[CH]};
    end

    vx_commit_lane #(.NUM_EX(NUM_EX), .BUF_DEPTH(BUF_DEPTH), .ARB_MODE(ARB_MODE)) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (vld),
      .in_ready (rdy),
      .in_entry (ent),
      .wb_ready (wb_ready[l]),
      .wb_valid (wb_valid[l]),
      .pop      (pop[l]),
      .head     (head)
    );

    assign wb_wid[l]   = head.wid;
    assign wb_tmask[l] = head.tmask;
    assign wb_eop[l]   = head.eop;
    assign wb_data[l]  = head.data;
    assign pc[l]       = pop[l] ? popcount(head.tmask) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cmt_q  <= 1'b0;
        cwid_q <= '0;
      end else begin
        cmt_q <= pop[l] && head.eop;
        if (pop[l] && head.eop) cwid_q <= head.wid;
      end
    end
    assign committed[l]     = cmt_q;
    assign committed_wid[l] = cwid_q;
  end

  always_comb begin
    sum = '0;
    for (int l = 0; l < LANES; l++) sum = sum + SW'(pc[l]);
  end

  // stage 1 captures the cross-lane sum, stage 2 accumulates (wraps modulo 2^CTR_W)
  assign vld_pipe[0] = |pop;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe[1] <= 1'b0;
      sum_q       <= '0;
      instret     <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      sum_q       <= sum;
      if (vld_pipe[1]) instret <= instret + CTR_W'(sum_q);
    end
  end
endmodule

// File: tb/tb_vx_commit_multi.sv
// Directed bench for vx_commit_multi: round-robin, fixed-priority and narrow-counter instances share stimulus.
module tb_vx_commit_multi;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]        in_valid, in_wb, in_eop;
  logic [7:0][1:0]   in_wid;
  logic [7:0][3:0]   in_tmask;
  logic [7:0][63:0]  in_data;
  logic [1:0]        wb_ready;

  logic [7:0]       r_in_ready, p_in_ready, w_in_ready;
  logic [1:0]       r_wb_valid, p_wb_valid, w_wb_valid;
  logic [1:0][1:0]  r_wb_wid, p_wb_wid, w_wb_wid;
  logic [1:0][3:0]  r_wb_tmask, p_wb_tmask, w_wb_tmask;
  logic [1:0]       r_wb_eop, p_wb_eop, w_wb_eop;
  logic [1:0][63:0] r_wb_data, p_wb_data, w_wb_data;
  logic [1:0]       r_committed, p_committed, w_committed;
  logic [1:0][1:0]  r_committed_wid, p_committed_wid, w_committed_wid;
  logic [43:0]      r_instret, p_instret;
  logic [3:0]       w_instret;

  int checks = 0;
  int errors = 0;

  vx_commit_multi u_rr (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(r_in_ready), .in_wid(in_wid),
    .in_tmask(in_tmask), .in_wb(in_wb), .in_eop(in_eop), .in_data(in_data), .wb_valid(r_wb_valid),
    .wb_ready(wb_ready), .wb_wid(r_wb_wid), .wb_tmask(r_wb_tmask), .wb_eop(r_wb_eop),
    .wb_data(r_wb_data), .committed(r_committed), .committed_wid(r_committed_wid), .instret(r_instret));

  vx_commit_multi #(.ARB_MODE("P")) u_p (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(p_in_ready), .in_wid(in_wid),
    .in_tmask(in_tmask), .in_wb(in_wb), .in_eop(in_eop), .in_data(in_data), .wb_valid(p_wb_valid),
    .wb_ready(wb_ready), .wb_wid(p_wb_wid), .wb_tmask(p_wb_tmask), .wb_eop(p_wb_eop),
    .wb_data(p_wb_data), .committed(p_committed), .committed_wid(p_committed_wid), .instret(p_instret));

  vx_commit_multi #(.CTR_W(4)) u_w (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(w_in_ready), .in_wid(in_wid),
    .in_tmask(in_tmask), .in_wb(in_wb), .in_eop(in_eop), .in_data(in_data), .wb_valid(w_wb_valid),
    .wb_ready(wb_ready), .wb_wid(w_wb_wid), .wb_tmask(w_wb_tmask), .wb_eop(w_wb_eop),
    .wb_data(w_wb_data), .committed(w_committed), .committed_wid(w_committed_wid), .instret(w_instret));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = '0; in_wb = '0; in_eop = '0; in_wid = '0; in_tmask = '0; in_data = '0;
  endtask

  task automatic set_ch(input int ch, input logic [1:0] wid, input logic [3:0] tm,
                        input logic wb, input logic eop, input logic [63:0] d);
    in_valid[ch] = 1'b1; in_wid[ch] = wid; in_tmask[ch] = tm;
    in_wb[ch] = wb; in_eop[ch] = eop; in_data[ch] = d;
  endtask

  task automatic do_reset();
    clear_inputs();
    wb_ready = '0;
    reset_n  = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (r_wb_valid !== 2'b00) begin errors++; $display("FAIL rst_wb_valid got %b exp 00", r_wb_valid); end
    checks++; if (r_committed !== 2'b00) begin errors++; $display("FAIL rst_committed got %b exp 00", r_committed); end
    checks++; if (r_instret !== 44'd0) begin errors++; $display("FAIL rst_instret got %0d exp 0", r_instret); end
    set_ch(0, 2'd1, 4'b0001, 1'b1, 1'b1, 64'hA);
    tick();
    in_data[0] = 64'hB;
    tick();
    clear_inputs();
    checks++; if (r_wb_valid[0] !== 1'b1 || r_wb_data[0] !== 64'hA)
      begin errors++; $display("FAIL pre_rst_head got v=%b d=%h exp v=1 d=a", r_wb_valid[0], r_wb_data[0]); end
    reset_n = 1'b0;
    #1;
    checks++; if (r_wb_valid !== 2'b00) begin errors++; $display("FAIL async_wb_valid got %b exp 00", r_wb_valid); end
    checks++; if (r_wb_data[0] !== 64'h0) begin errors++; $display("FAIL async_wb_data got %h exp 0", r_wb_data[0]); end
    checks++; if (r_committed !== 2'b00 || r_instret !== 44'd0)
      begin errors++; $display("FAIL async_cmt got c=%b i=%0d exp 0", r_committed, r_instret); end
    tick(); tick();
    reset_n  = 1'b1;
    wb_ready = 2'b11;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (r_wb_valid !== 2'b00 || r_committed !== 2'b00)
        begin errors++; $display("FAIL stale_entry cyc %0d got v=%b c=%b exp 0", k, r_wb_valid, r_committed); end
    end
    checks++; if (r_instret !== 44'd0) begin errors++; $display("FAIL stale_instret got %0d exp 0", r_instret); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_r;
    do_reset();
    wb_ready = 2'b11;
    for (int e = 0; e < 4; e++) set_ch(e * 2, 2'd0, 4'b0001, 1'b1, 1'b1, 64'(100 + e));
    for (int k = 0; k < 5; k++) begin
      #1;
      exp_r = 8'h01 << (2 * (k % 4));
      checks++; if (r_in_ready !== exp_r)
        begin errors++; $display("FAIL rr_grant cyc %0d got %b exp %b", k, r_in_ready, exp_r); end
      checks++; if (p_in_ready !== 8'h01)
        begin errors++; $display("FAIL prio_grant cyc %0d got %b exp 00000001", k, p_in_ready); end
      if (k > 0) begin
        checks++; if (r_wb_valid[0] !== 1'b1 || r_wb_data[0] !== 64'(100 + (k - 1) % 4))
          begin errors++; $display("FAIL rr_head cyc %0d got v=%b d=%0d exp v=1 d=%0d", k, r_wb_valid[0], r_wb_data[0], 100 + (k - 1) % 4); end
      end
      tick();
    end
    clear_inputs();
    repeat (3) tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    wb_ready = 2'b00;
    for (int e = 0; e < 3; e++) set_ch(e * 2, 2'd2, 4'b0011, 1'b1, 1'b0, 64'hA0 + 64'(e));
    #1;
    checks++; if (r_in_ready !== 8'h01) begin errors++; $display("FAIL bp_acc0 got %b exp 00000001", r_in_ready); end
    tick();
    checks++; if (r_in_ready !== 8'h04) begin errors++; $display("FAIL bp_acc1 got %b exp 00000100", r_in_ready); end
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++; if (r_in_ready !== 8'h00) begin errors++; $display("FAIL bp_full cyc %0d got %b exp 0", k, r_in_ready); end
      checks++; if (r_wb_valid[0] !== 1'b1 || r_wb_data[0] !== 64'hA0)
        begin errors++; $display("FAIL bp_hold cyc %0d got v=%b d=%h exp v=1 d=a0", k, r_wb_valid[0], r_wb_data[0]); end
      tick();
    end
    wb_ready = 2'b01;
    #1;
    checks++; if (r_in_ready !== 8'h00) begin errors++; $display("FAIL bp_full_pop got %b exp 0", r_in_ready); end
    tick();
    checks++; if (r_wb_data[0] !== 64'hA1) begin errors++; $display("FAIL bp_head1 got %h exp a1", r_wb_data[0]); end
    checks++; if (r_in_ready !== 8'h10) begin errors++; $display("FAIL bp_acc2 got %b exp 00010000", r_in_ready); end
    tick();
    clear_inputs();
    #1;
    checks++; if (r_wb_valid[0] !== 1'b1 || r_wb_data[0] !== 64'hA2)
      begin errors++; $display("FAIL bp_head2 got v=%b d=%h exp v=1 d=a2", r_wb_valid[0], r_wb_data[0]); end
    repeat (3) tick();
  endtask

  task automatic test_wb0();
    do_reset();
    wb_ready = 2'b00;
    set_ch(0, 2'd3, 4'b1011, 1'b0, 1'b1, 64'h55);
    tick();
    clear_inputs();
    checks++; if (r_wb_valid[0] !== 1'b0) begin errors++; $display("FAIL wb0_valid got %b exp 0", r_wb_valid[0]); end
    tick();
    checks++; if (r_committed[0] !== 1'b1 || r_committed_wid[0] !== 2'd3)
      begin errors++; $display("FAIL wb0_commit got c=%b w=%0d exp c=1 w=3", r_committed[0], r_committed_wid[0]); end
    checks++; if (r_instret !== 44'd0) begin errors++; $display("FAIL wb0_instret_early got %0d exp 0", r_instret); end
    tick();
    checks++; if (r_instret !== 44'd3) begin errors++; $display("FAIL wb0_instret got %0d exp 3", r_instret); end
    checks++; if (r_committed[0] !== 1'b0) begin errors++; $display("FAIL wb0_pulse got %b exp 0", r_committed[0]); end
  endtask

  task automatic test_simul_lanes();
    do_reset();
    wb_ready = 2'b11;
    set_ch(0, 2'd1, 4'b1111, 1'b1, 1'b1, 64'h10);
    set_ch(1, 2'd2, 4'b1111, 1'b1, 1'b1, 64'h11);
    tick();
    clear_inputs();
    checks++; if (r_wb_valid !== 2'b11) begin errors++; $display("FAIL sim_wb_valid got %b exp 11", r_wb_valid); end
    tick();
    checks++; if (r_committed !== 2'b11 || r_committed_wid[1] !== 2'd2)
      begin errors++; $display("FAIL sim_commit got c=%b w1=%0d exp c=11 w1=2", r_committed, r_committed_wid[1]); end
    checks++; if (r_instret !== 44'd0) begin errors++; $display("FAIL sim_instret_early got %0d exp 0", r_instret); end
    tick();
    checks++; if (r_instret !== 44'd8) begin errors++; $display("FAIL sim_instret got %0d exp 8", r_instret); end
  endtask

  task automatic test_wrap();
    do_reset();
    wb_ready = 2'b11;
    set_ch(0, 2'd0, 4'b0001, 1'b1, 1'b1, 64'h1);
    for (int i = 0; i < 14; i++) tick();
    in_tmask[0] = 4'b0111;
    tick();
    clear_inputs();
    tick();
    checks++; if (w_instret !== 4'd14) begin errors++; $display("FAIL wrap_pre got %0d exp 14", w_instret); end
    tick();
    checks++; if (w_instret !== 4'd1) begin errors++; $display("FAIL wrap_post got %0d exp 1", w_instret); end
    checks++; if (r_instret !== 44'd17) begin errors++; $display("FAIL wide_total got %0d exp 17", r_instret); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    wb_ready = '0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_wb0();
    test_simul_lanes();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
